// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Byte-addressable data memory with a fixed-latency request/response
//   handshake. A request is taken in IDLE. The responder then waits
//   WAIT_CYCLES cycles in ACCESS, performs the load or store, and drives a
//   one-cycle response in RESP.
//
//   Parameters
//     DEPTH_WORDS : number of 32-bit words in storage (power of two)
//     WAIT_CYCLES : extra access cycles before each response (0..15)
//
//   Ports
//     clk_i    : clock, rising edge
//     rst_i    : asynchronous active-high reset (storage is not cleared)
//     req_i    : request from the core
//     ready_o  : request accepted this cycle (high only in IDLE)
//     we_i     : 1 = store, 0 = load
//     size_i   : 00 byte, 01 half, 10 word, 11 reserved (error)
//     addr_i   : byte address; wraps modulo 4*DEPTH_WORDS
//     wdata_i  : store data, right-aligned
//     rvalid_o : one-cycle response strobe
//     rdata_o  : load data, right-aligned and zero-extended; 0 for stores and errors
//     err_o    : error flag, qualified by rvalid_o
//
//   Optional feature
//     DMEM_ALIGN_CHECK_EN : when defined, a misaligned half or word access
//     returns an error and does not write. When undefined, the misaligned
//     low address bits are forced to the alignment of the access size.

`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 32
`endif
`ifndef REG_DATA_WIDTH
`define REG_DATA_WIDTH 32
`endif

module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       req_i,
  output logic                       ready_o,
  input  logic                       we_i,
  input  logic [1:0]                 size_i,
  input  logic [`MEM_ADDR_WIDTH-1:0] addr_i,
  input  logic [`REG_DATA_WIDTH-1:0] wdata_i,
  output logic                       rvalid_o,
  output logic [`REG_DATA_WIDTH-1:0] rdata_o,
  output logic                       err_o
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int BA_W  = IDX_W + 2;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q;
  logic              do_access;
  logic              accept;

  // Captured request (stage p0); data-only, no reset needed.
  logic              we_p0;
  logic [1:0]        size_p0;
  logic [BA_W-1:0]   addr_p0;
  logic [31:0]       wdata_p0;

  logic [31:0]       mem [DEPTH_WORDS];

  logic              misalign;
  logic              acc_err;
  logic [1:0]        off;
  logic [IDX_W-1:0]  idx;
  logic [3:0]        be;
  logic [31:0]       wd_aligned;

  // Byte lane of the lowest addressed byte; low bits forced to size alignment.
  function automatic logic [1:0] lane_off(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      2'b00:   lane_off = a;
      2'b01:   lane_off = {a[1], 1'b0};
      default: lane_off = 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] sz, input logic [1:0] o);
    case (sz)
      2'b00:   byte_en = 4'b0001 << o;
      2'b01:   byte_en = 4'b0011 << o;
      2'b10:   byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] sz,
                                               input logic [1:0] o);
    logic [31:0] sh;
    sh = w >> {o, 3'b000};
    case (sz)
      2'b00:   load_extract = {24'h0, sh[7:0]};
      2'b01:   load_extract = {16'h0, sh[15:0]};
      2'b10:   load_extract = sh;
      default: load_extract = 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] store_align(input logic [31:0] wd, input logic [1:0] o);
    store_align = wd << {o, 3'b000};
  endfunction

  // FSM state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state and handshake outputs
  always_comb begin
    state_d   = state_q;
    ready_o   = 1'b0;
    rvalid_o  = 1'b0;
    do_access = 1'b0;
    case (state_q)
      IDLE: begin
        ready_o = 1'b1;
        if (req_i) state_d = ACCESS;
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          do_access = 1'b1;
          state_d   = RESP;
        end
      end
      RESP: begin
        rvalid_o = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept = req_i & ready_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                                  cnt_q <= 4'd0;
    else if (accept)                            cnt_q <= 4'(WAIT_CYCLES);
    else if (state_q == ACCESS && cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
  end

  // ---- stage p0: request capture ----
  always_ff @(posedge clk_i) begin
    if (accept) begin
      we_p0    <= we_i;
      size_p0  <= size_i;
      addr_p0  <= addr_i[BA_W-1:0];
      wdata_p0 <= wdata_i[31:0];
    end
  end

`ifdef DMEM_ALIGN_CHECK_EN
  assign misalign = ((size_p0 == 2'b01) && addr_p0[0]) ||
                    ((size_p0 == 2'b10) && (addr_p0[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign acc_err    = (size_p0 == 2'b11) | misalign;
  assign off        = lane_off(size_p0, addr_p0[1:0]);
  assign idx        = addr_p0[BA_W-1:2];
  assign be         = byte_en(size_p0, off);
  assign wd_aligned = store_align(wdata_p0, off);

  // ---- stage p1: memory operation and response capture ----
  always_ff @(posedge clk_i) begin
    if (do_access && we_p0 && !acc_err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wd_aligned[8*i +: 8];
      end
    end
  end

  // Response data is registered so it holds steady outside RESP.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_o <= '0;
      err_o   <= 1'b0;
    end else if (do_access) begin
      err_o   <= acc_err;
      rdata_o <= (we_p0 || acc_err) ? '0 : `REG_DATA_WIDTH'(load_extract(mem[idx], size_p0, off));
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  logic        clk;
  logic [2:0]  rst_v;
  logic        req_v   [3];
  logic        we_v    [3];
  logic [1:0]  size_v  [3];
  logic [31:0] addr_v  [3];
  logic [31:0] wdata_v [3];
  logic        ready_v [3];
  logic        rvalid_v[3];
  logic [31:0] rdata_v [3];
  logic        err_v   [3];

  int tests = 0;
  int fails = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // u0: WAIT_CYCLES=1, u1: WAIT_CYCLES=3, u2: WAIT_CYCLES=0
  data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1)) u_w1 (
    .clk_i(clk), .rst_i(rst_v[0]), .req_i(req_v[0]), .ready_o(ready_v[0]),
    .we_i(we_v[0]), .size_i(size_v[0]), .addr_i(addr_v[0]), .wdata_i(wdata_v[0]),
    .rvalid_o(rvalid_v[0]), .rdata_o(rdata_v[0]), .err_o(err_v[0]));

  data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(3)) u_w3 (
    .clk_i(clk), .rst_i(rst_v[1]), .req_i(req_v[1]), .ready_o(ready_v[1]),
    .we_i(we_v[1]), .size_i(size_v[1]), .addr_i(addr_v[1]), .wdata_i(wdata_v[1]),
    .rvalid_o(rvalid_v[1]), .rdata_o(rdata_v[1]), .err_o(err_v[1]));

  data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_w0 (
    .clk_i(clk), .rst_i(rst_v[2]), .req_i(req_v[2]), .ready_o(ready_v[2]),
    .we_i(we_v[2]), .size_i(size_v[2]), .addr_i(addr_v[2]), .wdata_i(wdata_v[2]),
    .rvalid_o(rvalid_v[2]), .rdata_o(rdata_v[2]), .err_o(err_v[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request on unit u starting at a negedge; returns the response
  // and the number of cycles from acceptance to the rvalid cycle.
  task automatic txn(input int u, input logic we, input logic [1:0] sz,
                     input logic [31:0] a, input logic [31:0] wd,
                     output logic [31:0] rd, output logic er, output int lat);
    chk("ready_before_req", 32'(ready_v[u]), 32'd1);
    req_v[u] = 1'b1; we_v[u] = we; size_v[u] = sz; addr_v[u] = a; wdata_v[u] = wd;
    @(posedge clk);
    @(negedge clk);
    req_v[u] = 1'b0;
    lat = 1;
    while (rvalid_v[u] !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("rvalid_timeout", 32'(lat < 40), 32'd1);
    rd = rdata_v[u];
    er = err_v[u];
    @(negedge clk);
    chk("rdata_hold", rdata_v[u], rd);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          rv_seen;

    rst_v = 3'b111;
    for (int i = 0; i < 3; i++) begin
      req_v[i] = 1'b0; we_v[i] = 1'b0; size_v[i] = 2'b00;
      addr_v[i] = 32'h0; wdata_v[i] = 32'h0;
    end
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready",  32'(ready_v[0]),  32'd1);
    chk("rst_rvalid", 32'(rvalid_v[0]), 32'd0);
    chk("rst_rdata",  rdata_v[0],       32'h0);
    chk("rst_err",    32'(err_v[0]),    32'd0);
    rst_v = 3'b000;
    @(negedge clk);

    // Word store / load, latency WAIT_CYCLES+2 = 3
    txn(0, 1'b1, 2'b10, 32'h10, 32'hDEADBEEF, rd, er, lat);
    chk("sw_lat", 32'(lat), 32'd3);
    chk("sw_err", 32'(er), 32'd0);
    chk("sw_rdata_zero", rd, 32'h0);
    txn(0, 1'b0, 2'b10, 32'h10, 32'h0, rd, er, lat);
    chk("lw_10", rd, 32'hDEADBEEF);
    chk("lw_lat", 32'(lat), 32'd3);

    // Byte store into lane 3; only the low byte of wdata is used
    txn(0, 1'b1, 2'b00, 32'h13, 32'h123456A5, rd, er, lat);
    txn(0, 1'b0, 2'b10, 32'h10, 32'h0, rd, er, lat);
    chk("lw_after_sb", rd, 32'hA5ADBEEF);
    txn(0, 1'b0, 2'b00, 32'h13, 32'h0, rd, er, lat);
    chk("lb_13", rd, 32'h000000A5);

    // Half store into upper lanes
    txn(0, 1'b1, 2'b01, 32'h12, 32'hCAFE1234, rd, er, lat);
    txn(0, 1'b0, 2'b01, 32'h12, 32'h0, rd, er, lat);
    chk("lh_12", rd, 32'h00001234);
    txn(0, 1'b0, 2'b10, 32'h10, 32'h0, rd, er, lat);
    chk("lw_after_sh", rd, 32'h1234BEEF);
    txn(0, 1'b0, 2'b00, 32'h11, 32'h0, rd, er, lat);
    chk("lb_11", rd, 32'h000000BE);

    // Misaligned half and word loads
    txn(0, 1'b0, 2'b01, 32'h11, 32'h0, rd, er, lat);
`ifdef DMEM_ALIGN_CHECK_EN
    chk("lh_mis_err", 32'(er), 32'd1);
    chk("lh_mis_rdata", rd, 32'h0);
`else
    chk("lh_mis_err", 32'(er), 32'd0);
    chk("lh_mis_rdata", rd, 32'h0000BEEF);
`endif
    txn(0, 1'b0, 2'b10, 32'h12, 32'h0, rd, er, lat);
`ifdef DMEM_ALIGN_CHECK_EN
    chk("lw_mis_err", 32'(er), 32'd1);
    chk("lw_mis_rdata", rd, 32'h0);
`else
    chk("lw_mis_err", 32'(er), 32'd0);
    chk("lw_mis_rdata", rd, 32'h1234BEEF);
`endif

    // Reserved size: error, no write, same latency
    txn(0, 1'b1, 2'b11, 32'h10, 32'h00000000, rd, er, lat);
    chk("rsv_err", 32'(er), 32'd1);
    chk("rsv_rdata", rd, 32'h0);
    chk("rsv_lat", 32'(lat), 32'd3);
    txn(0, 1'b0, 2'b10, 32'h10, 32'h0, rd, er, lat);
    chk("rsv_nowrite", rd, 32'h1234BEEF);
    chk("err_clear", 32'(er), 32'd0);

    // Address wrap modulo 4*DEPTH_WORDS = 0x1000
    txn(0, 1'b1, 2'b10, 32'h1024, 32'hCAFEBABE, rd, er, lat);
    txn(0, 1'b0, 2'b10, 32'h24, 32'h0, rd, er, lat);
    chk("wrap", rd, 32'hCAFEBABE);

    // Reset aborting a store (WAIT_CYCLES=3)
    txn(1, 1'b1, 2'b10, 32'h20, 32'h77777777, rd, er, lat);
    chk("w3_lat", 32'(lat), 32'd5);
    chk("w3_ready_pre", 32'(ready_v[1]), 32'd1);
    req_v[1] = 1'b1; we_v[1] = 1'b1; size_v[1] = 2'b10; addr_v[1] = 32'h20; wdata_v[1] = 32'h55;
    @(posedge clk);
    @(negedge clk);
    req_v[1] = 1'b0;
    chk("abort_busy", 32'(ready_v[1]), 32'd0);
    rst_v[1] = 1'b1;
    #1;
    chk("abort_ready", 32'(ready_v[1]), 32'd1);
    chk("abort_rvalid", 32'(rvalid_v[1]), 32'd0);
    @(negedge clk);
    rst_v[1] = 1'b0;
    rv_seen = 0;
    for (int k = 0; k < 8; k++) begin
      if (rvalid_v[1] === 1'b1) rv_seen++;
      @(negedge clk);
    end
    chk("abort_no_rvalid", 32'(rv_seen), 32'd0);
    txn(1, 1'b0, 2'b10, 32'h20, 32'h0, rd, er, lat);
    chk("abort_nowrite", rd, 32'h77777777);

    // Back-to-back with req held high (WAIT_CYCLES=0): period of 3 cycles
    req_v[2] = 1'b1; we_v[2] = 1'b1; size_v[2] = 2'b10; addr_v[2] = 32'h0; wdata_v[2] = 32'h0;
    for (int k = 0; k < 15; k++) begin
      chk($sformatf("b2b_ready_%0d", k),  32'(ready_v[2]),  32'((k % 3) == 0));
      chk($sformatf("b2b_rvalid_%0d", k), 32'(rvalid_v[2]), 32'((k % 3) == 2));
      @(negedge clk);
    end
    req_v[2] = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
